// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg
// Shared constants for the memory-mapped UART transmitter:
//   - register offsets (word index iAddress[3:2] inside the 16-byte window)
//   - STATUS bit positions
//   - TX FSM state encoding (2 bits)
//   - div_eff(): maps a programmed divisor of 0 onto 1
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVR       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A divisor of zero would otherwise give zero-length bits.
  function automatic logic [15:0] div_eff(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_fifo
// Synchronous byte FIFO, first-word-fall-through (oData shows the head entry).
// Ports:
//   iCLK, iRST (async, active-low)
//   iPush/iData : write one byte; ignored when full unless a pop happens in the same cycle
//   iPop        : remove the head entry; ignored when empty
//   oData       : head entry
//   oFull, oEmpty, oCount : occupancy, updated on the edge after a push/pop
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iPush,
  input  logic                      iPop,
  input  logic [7:0]                iData,
  output logic [7:0]                oData,
  output logic                      oFull,
  output logic                      oEmpty,
  output logic [$clog2(DEPTH):0]    oCount
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_pop;
  logic        w_do_push;

  assign w_do_pop  = iPop & ~oEmpty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign w_do_push = iPush & (~oFull | w_do_pop);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset: the pointers alone define what is valid.
  always_ff @(posedge iCLK) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= iData;
  end

  assign oData  = r_mem[r_rd_ptr[AW-1:0]];
  assign oEmpty = (r_wr_ptr == r_rd_ptr);
  assign oFull  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign oCount = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO.
// Window at BASE_ADDR: +0 DATA (write-only), +4 STATUS, +8 DIV, +C reserved.
// Ports:
//   iCLK, iRST (async, active-low)
//   iReadEnable, iWriteEnable, iByteEnable[3:0], iAddress[31:0], iWriteData[31:0] : CPU data bus
//   oReadData[31:0] : combinational load data, zero when this block is not read
//   oTX             : serial line, idle high, registered
//   oIRQ            : high when FIFO empty and transmitter idle, registered
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFF20_0110,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oTX,
  output logic        oIRQ
);

  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- decode ----------------
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_data_wr;
  logic       w_ovr_clr;
  logic       w_div_wr;
  logic       w_unused_bits;

  assign w_hit     = (iAddress[31:4] == BASE_ADDR[31:4]);
  assign w_off     = iAddress[3:2];
  assign w_data_wr = iWriteEnable & w_hit & (w_off == OFF_DATA) & iByteEnable[0];
  assign w_ovr_clr = iWriteEnable & w_hit & (w_off == OFF_STATUS) & iByteEnable[0]
                     & iWriteData[ST_OVR];
  assign w_div_wr  = iWriteEnable & w_hit & (w_off == OFF_DIV);
  assign w_unused_bits = &{iAddress[1:0], iByteEnable[3:2], iWriteData[31:16]};

  // ---------------- FIFO ----------------
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_data;
  logic [CW-1:0] w_count;
  logic [3:0]    w_count4;

  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iPush  (w_data_wr),
    .iPop   (w_pop),
    .iData  (iWriteData[7:0]),
    .oData  (w_fifo_data),
    .oFull  (w_full),
    .oEmpty (w_empty),
    .oCount (w_count)
  );

  assign w_count4 = 4'(w_count);

  // ---------------- OVR ----------------
  logic r_ovr;
  logic w_overrun;

  assign w_overrun = w_data_wr & w_full & ~w_pop;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)          r_ovr <= 1'b0;
    else if (w_overrun) r_ovr <= 1'b1;   // set beats a same-cycle clear
    else if (w_ovr_clr) r_ovr <= 1'b0;
  end

  // ---------------- DIV, one register per byte lane ----------------
  logic [15:0] w_div;
  logic [15:0] w_reload;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_div_lane
      logic [7:0] r_byte;
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)                              r_byte <= DEFAULT_DIV[gi*8 +: 8];
        else if (w_div_wr && iByteEnable[gi])   r_byte <= iWriteData[gi*8 +: 8];
      end
      assign w_div[gi*8 +: 8] = r_byte;
    end
  endgenerate

  // Baud counter counts down to zero, so a bit lasts (reload + 1) cycles.
  assign w_reload = div_eff(w_div) - 16'd1;

  // ---------------- TX FSM ----------------
  tx_state_t   r_state, w_state_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [2:0]  r_bitcnt, w_bitcnt_next;
  logic [15:0] r_baud, w_baud_next;
  logic        r_tx, w_tx_next;
  logic        r_irq, w_irq_next;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_baud   <= '0;
      r_tx     <= 1'b1;
      r_irq    <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bitcnt <= w_bitcnt_next;
      r_baud   <= w_baud_next;
      r_tx     <= w_tx_next;
      r_irq    <= w_irq_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bitcnt_next = r_bitcnt;
    w_baud_next   = r_baud;
    w_tx_next     = r_tx;
    w_pop         = 1'b0;
    w_irq_next    = w_empty & (r_state == S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_data;
          w_tx_next    = 1'b0;
          w_baud_next  = w_reload;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_baud == 16'd0) begin
          w_tx_next     = r_shift[0];
          w_shift_next  = {1'b0, r_shift[7:1]};
          w_bitcnt_next = 3'd0;
          w_baud_next   = w_reload;
          w_state_next  = S_DATA;
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      S_DATA: begin
        if (r_baud == 16'd0) begin
          w_baud_next = w_reload;
          if (r_bitcnt == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_tx_next     = r_shift[0];
            w_shift_next  = {1'b0, r_shift[7:1]};
            w_bitcnt_next = r_bitcnt + 3'd1;
          end
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      S_STOP: begin
        if (r_baud == 16'd0) begin
          if (!w_empty) begin
            // Back-to-back frame: no idle cycle between stop and start.
            w_pop        = 1'b1;
            w_shift_next = w_fifo_data;
            w_tx_next    = 1'b0;
            w_baud_next  = w_reload;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign oTX  = r_tx;
  assign oIRQ = r_irq;

  // ---------------- read path ----------------
  logic [7:0] w_status;

  always_comb begin
    w_status                         = '0;
    w_status[ST_FULL]                = w_full;
    w_status[ST_EMPTY]               = w_empty;
    w_status[ST_BUSY]                = (r_state != S_IDLE);
    w_status[ST_OVR]                 = r_ovr;
    w_status[ST_COUNT_LSB +: 4]      = w_count4;
  end

  always_comb begin
    oReadData = '0;
    if (iReadEnable && w_hit) begin
      case (w_off)
        OFF_STATUS: oReadData = {24'd0, w_status};
        OFF_DIV:    oReadData = {16'd0, w_div};
        default:    oReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFF20_0110;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [3:0]  be;
  logic [31:0] addr, wd;
  logic [31:0] rd;
  logic        tx, irq;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .iCLK         (clk),
    .iRST         (rst_n),
    .iReadEnable  (re),
    .iWriteEnable (we),
    .iByteEnable  (be),
    .iAddress     (addr),
    .iWriteData   (wd),
    .oReadData    (rd),
    .oTX          (tx),
    .oIRQ         (irq)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // FIFO as a queue; a frame as a 10-entry bit list with a per-bit cycle budget.
  logic [7:0]  mq[$];
  bit          m_ovr;
  logic [15:0] m_div;
  bit          m_active;
  bit          m_frame[10];
  int          m_bit, m_rem;
  bit          m_tx, m_irq;

  function automatic int deff();
    return (m_div == 16'd0) ? 1 : int'(m_div);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovr = 0; m_div = 16'd434; m_active = 0;
    m_bit = 0; m_rem = 0; m_tx = 1; m_irq = 1;
  endtask

  task automatic m_start();
    logic [7:0] b;
    b = mq.pop_front();
    m_frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_frame[i+1] = b[i];
    m_frame[9] = 1'b1;
    m_bit = 0; m_rem = deff(); m_tx = 0; m_active = 1;
  endtask

  function automatic logic [31:0] m_rdata();
    logic [31:0] s;
    if (!re || addr[31:4] != BASE[31:4]) return 32'd0;
    case (addr[3:2])
      2'd1: begin
        s = 32'(mq.size()) << 4;
        s[3] = m_ovr; s[2] = m_active;
        s[1] = (mq.size() == 0); s[0] = (mq.size() == DEPTH);
        return s;
      end
      2'd2:    return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        bit hit, ovr_set;
        hit = (addr[31:4] == BASE[31:4]);
        ovr_set = 0;
        m_irq = (mq.size() == 0) && !m_active;
        if (!m_active) begin
          if (mq.size() != 0) m_start();
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_bit++;
            if (m_bit == 10) begin
              if (mq.size() != 0) m_start();
              else begin m_active = 0; m_tx = 1; end
            end else begin
              m_tx = m_frame[m_bit];
              m_rem = deff();
            end
          end
        end
        if (we && hit && addr[3:2] == 2'd0 && be[0]) begin
          if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
          else ovr_set = 1;
        end
        if (we && hit && addr[3:2] == 2'd1 && be[0] && wd[3]) m_ovr = 0;
        if (ovr_set) m_ovr = 1;
        if (we && hit && addr[3:2] == 2'd2) begin
          if (be[0]) m_div[7:0]  = wd[7:0];
          if (be[1]) m_div[15:8] = wd[15:8];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("tx", {31'd0, tx}, {31'd0, m_tx});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        if (re) check("rdata", rd, m_rdata());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    re = 0; we = 0; be = 4'd0; addr = 32'd0; wd = 32'd0;
  endtask

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] b);
    re = 0; we = 1; be = b; wd = d; addr = BASE + (32'(off) << 2);
    $display("wr  addr=0x%08h data=0x%08h be=%b", addr, d, b);
    tick();
    we = 0; be = 4'd0;
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    re = 1; addr = a;
    @(negedge clk);
    $display("rd  addr=0x%08h data=0x%08h", a, rd);
    check(name, rd, exp);
    tick();
    re = 0;
  endtask

  // Literal frame shape after a push at the previous edge: start, 8 data LSB first, stop.
  task automatic frame_check(input logic [7:0] b, input int d, input string name);
    int bi;
    logic e;
    for (int i = 0; i < 10 * d; i++) begin
      @(posedge clk); @(negedge clk);
      bi = i / d;
      if (bi == 0) e = 1'b0;
      else if (bi == 9) e = 1'b1;
      else e = b[bi-1];
      check(name, {31'd0, tx}, {31'd0, e});
    end
    @(posedge clk); @(negedge clk);
    check({name, "_irq_lo"}, {31'd0, irq}, 32'd0);
    @(posedge clk); @(negedge clk);
    check({name, "_irq_hi"}, {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(mq.size() == 0 && !m_active && m_irq) && n < 3000) begin
      tick(); n++;
    end
    if (n >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, got busy, expected idle within 3000 cycles", name);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_bus();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    tick();
    chk_en = 1;

    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    rd_check(BASE + 32'h4, 32'h0000_0002, "reset_status");
    rd_check(BASE + 32'h8, 32'd434, "reset_div");

    // DIV=4, one 0x55 frame
    wr(2, 32'd4, 4'b0011);
    wr(0, 32'h55, 4'b0001);
    frame_check(8'h55, 4, "frame55");

    // DIV=2, burst to full and overrun
    wr(2, 32'd2, 4'b0011);
    for (int k = 0; k < 10; k++) wr(0, 32'(k), 4'b0001);
    rd_check(BASE + 32'h4, 32'h0000_008D, "full_ovr_status");
    wr(1, 32'h8, 4'b0001);
    rd_check(BASE + 32'h4, 32'h0000_0085, "ovr_cleared");
    wr(0, 32'hAA, 4'b0001);
    rd_check(BASE + 32'h4, 32'h0000_008D, "ovr_again");
    wr(1, 32'h8, 4'b0010);
    rd_check(BASE + 32'h4, 32'h0000_008D, "ovr_clear_needs_lane0");
    wait_idle("drain_burst");

    // DIV=0 behaves as 1
    wr(2, 32'd0, 4'b0011);
    rd_check(BASE + 32'h8, 32'd0, "div_zero_read");
    wr(0, 32'hFF, 4'b0001);
    frame_check(8'hFF, 1, "frameFF");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int unsigned op;
      op = $urandom_range(0, 11);
      re = 0; we = 0;
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      addr = BASE + (32'($urandom_range(0, 3)) << 2);
      case (op)
        0, 1, 2, 3: begin we = 1; addr = BASE; be[0] = ($urandom_range(0, 7) != 0); end
        4:          begin we = 1; addr = BASE + 32'h4; wd = 32'($urandom_range(0, 15)); end
        5:          begin we = 1; addr = BASE + 32'h8; wd = 32'($urandom_range(0, 3)); end
        6, 7, 8:    re = 1;
        9:          begin we = 1; addr = BASE + 32'hC; end
        default: begin
          addr = BASE + 32'h10 + (32'($urandom_range(0, 3)) << 2);
          we = ($urandom_range(0, 1) == 1);
          re = !we;
        end
      endcase
      tick();
    end
    idle_bus();
    wait_idle("drain_random");

    // reset in the middle of data bit 3 (0xA5 bit3 = 0, so the line is low)
    wr(2, 32'd4, 4'b0011);
    wr(0, 32'hA5, 4'b0001);
    repeat (18) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_irq", {31'd0, irq}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    rd_check(BASE + 32'h4, 32'h0000_0002, "post_reset_status");
    rd_check(BASE + 32'h8, 32'd434, "post_reset_div");
    for (int i = 0; i < 60; i++) begin
      tick();
      check("no_residual_frame", {31'd0, tx}, 32'd1);
    end

    rd_check(BASE + 32'hC, 32'd0, "rsvd_read");
    rd_check(BASE + 32'h0, 32'd0, "data_read");
    rd_check(BASE + 32'h14, 32'd0, "offwin_hi_read");
    rd_check(BASE - 32'h4, 32'd0, "offwin_lo_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
